// File: rtl/adsr_env_if.sv
// Envelope generator bus: control/sample inputs and envelope outputs.
// The master drives gate, rates, sustain and the oscillator sample; the slave returns the scaled sample and status.
interface adsr_env_if #(
  parameter int unsigned NBITS = 10
);
  logic             gate;
  logic [7:0]       attack_rate;
  logic [7:0]       decay_rate;
  logic [NBITS-1:0] sustain_level;
  logic [7:0]       release_rate;
  logic [NBITS-1:0] din;
  logic [NBITS-1:0] dout;
  logic [NBITS-1:0] env_level;
  logic [2:0]       state;
  logic             active;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate, din,
    input  dout, env_level, state, active
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate, din,
    output dout, env_level, state, active
  );
endinterface

// File: rtl/adsr_env.sv
// ADSR envelope generator: the level steps once per tick, and the oscillator sample is scaled by (level+1)/2^NBITS.
// Gate edges are handled on every clk and override a coincident tick.
module adsr_env #(
  parameter int unsigned NBITS    = 10,
  parameter int unsigned TICK_DIV = 1000
) (
  input logic       clk,
  input logic       rst_n,
  adsr_env_if.slave env
);

  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUM_W  = NBITS + 1;
  localparam int unsigned PROD_W = 2 * NBITS + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [NBITS-1:0] LVL_MAX = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gate_q;
  logic [2:0]        state_q, state_d;
  logic [NBITS-1:0]  level_q, level_d;
  logic [NBITS-1:0]  dout_q, dout_d;
  logic              active_q, active_d;

  logic              tick_c;
  logic              rise_c;
  logic              fall_c;
  logic [SUM_W-1:0]  level_ext_c;
  logic [SUM_W-1:0]  atk_sum_c;
  logic [SUM_W-1:0]  dec_thr_c;
  logic [SUM_W-1:0]  dec_diff_c;
  logic [SUM_W-1:0]  rel_rate_c;
  logic [SUM_W-1:0]  rel_diff_c;
  logic [PROD_W-1:0] prod_c;

  // A zero rate would stall the envelope forever, so it is promoted to 1.
  function automatic logic [SUM_W-1:0] rate_eff(input logic [7:0] r);
    return (r == 8'd0) ? SUM_W'(1) : SUM_W'(r);
  endfunction

  // Free-running tick divider.
  always_comb begin
    tick_c = (cnt_q == CNT_MAX);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // Next-state, level and scaled-sample logic.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    rise_c      = env.gate & ~gate_q;
    fall_c      = ~env.gate & gate_q;
    level_ext_c = SUM_W'(level_q);
    atk_sum_c   = level_ext_c + rate_eff(env.attack_rate);
    dec_thr_c   = SUM_W'(env.sustain_level) + rate_eff(env.decay_rate);
    dec_diff_c  = level_ext_c - rate_eff(env.decay_rate);
    rel_rate_c  = rate_eff(env.release_rate);
    rel_diff_c  = level_ext_c - rel_rate_c;

    if (rise_c) begin
      state_d = S_ATTACK;
    end else if (fall_c && (state_q == S_ATTACK || state_q == S_DECAY ||
                            state_q == S_SUSTAIN)) begin
      state_d = S_RELEASE;
    end else if (tick_c) begin
      case (state_q)
        S_IDLE: begin
          level_d = '0;
        end
        S_ATTACK: begin
          if (atk_sum_c >= SUM_W'(LVL_MAX)) begin
            level_d = LVL_MAX;
            state_d = S_DECAY;
          end else begin
            level_d = NBITS'(atk_sum_c);
          end
        end
        S_DECAY: begin
          if (level_ext_c <= dec_thr_c) begin
            level_d = env.sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            level_d = NBITS'(dec_diff_c);
          end
        end
        S_SUSTAIN: begin
          level_d = env.sustain_level;
        end
        S_RELEASE: begin
          if (level_ext_c <= rel_rate_c) begin
            level_d = '0;
            state_d = S_IDLE;
          end else begin
            level_d = NBITS'(rel_diff_c);
          end
        end
        default: begin
          level_d = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    // (level+1) makes full scale an exact pass-through of din.
    prod_c   = PROD_W'(env.din) * PROD_W'(level_ext_c + SUM_W'(1));
    dout_d   = NBITS'(prod_c >> NBITS);
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      gate_q   <= 1'b0;
      state_q  <= S_IDLE;
      level_q  <= '0;
      dout_q   <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      gate_q   <= env.gate;
      state_q  <= state_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      active_q <= active_d;
    end
  end

  assign env.dout      = dout_q;
  assign env.env_level = level_q;
  assign env.state     = state_q;
  assign env.active    = active_q;

endmodule

// File: tb/tb_adsr_env.sv
// Bench for adsr_env: directed envelope scenarios and random gate/rate activity,
// every cycle compared against a cycle-level reference envelope model.
module tb_adsr_env;
  localparam int NB   = 10;
  localparam int TD   = 4;
  localparam int MAXL = (1 << NB) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ATK  = 1;
  localparam int M_DEC  = 2;
  localparam int M_SUS  = 3;
  localparam int M_REL  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adsr_env_if #(.NBITS(NB)) bus ();

  adsr_env #(.NBITS(NB), .TICK_DIV(TD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .env  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_level, m_state, m_dout, m_cycles;
  bit m_gate_prev;

  int seen[$];
  int seq_att[5] = '{255, 510, 765, 1020, 1023};
  int seq_dec[5] = '{923, 823, 723, 623, 600};
  int seq_rel[5] = '{400, 200, 0, 0, 0};
  int seq_one[5] = '{500, 0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  task automatic model_reset();
    m_level = 0; m_state = M_IDLE; m_dout = 0; m_cycles = 0; m_gate_prev = 1'b0;
  endtask

  // One clk edge: predict from pre-edge inputs, then compare all outputs.
  task automatic cycle();
    int din_v, sus, nl, ns, nd;
    bit tk, rise, fall, g;
    din_v = int'(bus.din);
    sus   = int'(bus.sustain_level);
    g     = bus.gate;
    tk    = (m_cycles % TD) == (TD - 1);
    rise  = g && !m_gate_prev;
    fall  = !g && m_gate_prev;
    nl    = m_level;
    ns    = m_state;
    nd    = (din_v * (m_level + 1)) >> NB;
    if (rise) ns = M_ATK;
    else if (fall && (m_state == M_ATK || m_state == M_DEC || m_state == M_SUS)) ns = M_REL;
    else if (tk) begin
      case (m_state)
        M_ATK: if (m_level + eff(int'(bus.attack_rate)) >= MAXL) begin nl = MAXL; ns = M_DEC; end
               else nl = m_level + eff(int'(bus.attack_rate));
        M_DEC: if (m_level <= sus + eff(int'(bus.decay_rate))) begin nl = sus; ns = M_SUS; end
               else nl = m_level - eff(int'(bus.decay_rate));
        M_SUS: nl = sus;
        M_REL: if (m_level <= eff(int'(bus.release_rate))) begin nl = 0; ns = M_IDLE; end
               else nl = m_level - eff(int'(bus.release_rate));
        default: nl = 0;
      endcase
    end
    @(posedge clk);
    #1;
    m_level = nl; m_state = ns; m_dout = nd; m_gate_prev = g; m_cycles++;
    check("env_level", 32'(bus.env_level), 32'(m_level));
    check("state", 32'(bus.state), 32'(m_state));
    check("active", 32'(bus.active), 32'(m_state != M_IDLE));
    check("dout", 32'(bus.dout), 32'(m_dout));
  endtask

  task automatic run_until_state(input int st, input int max_cyc);
    int last;
    last = int'(bus.env_level);
    seen.delete();
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (int'(bus.env_level) != last) begin last = int'(bus.env_level); seen.push_back(last); end
      if (int'(bus.state) == st) break;
    end
    check("reach_state", 32'(bus.state), 32'(st));
  endtask

  task automatic run_until_level(input int lv, input int max_cyc);
    int last;
    last = int'(bus.env_level);
    seen.delete();
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (int'(bus.env_level) != last) begin last = int'(bus.env_level); seen.push_back(last); end
      if (int'(bus.env_level) == lv) break;
    end
    check("reach_level", 32'(bus.env_level), 32'(lv));
  endtask

  task automatic check_seq(input string tag, input int e[5], input int n);
    check({tag, "_len"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < seen.size()) check(tag, 32'(seen[i]), 32'(e[i]));
  endtask

  task automatic align_to_tick();
    for (int i = 0; i < TD; i++) begin
      if ((m_cycles % TD) == (TD - 1)) break;
      cycle();
    end
  endtask

  initial begin
    int lvl;
    rst_n = 1'b1;
    bus.gate = 1'b0; bus.attack_rate = 8'd255; bus.decay_rate = 8'd100;
    bus.sustain_level = 10'd600; bus.release_rate = 8'd200; bus.din = 10'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_env", 32'(bus.env_level), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Attack at full rate, decay into sustain
    bus.gate = 1'b1;
    run_until_state(M_DEC, 100);
    check_seq("attack_seq", seq_att, 5);
    run_until_state(M_SUS, 100);
    check_seq("decay_seq", seq_dec, 5);

    // Sustain tracks its input; dout scaling at half and full scale
    bus.sustain_level = 10'd500;
    run_until_level(500, 20);
    check("sus_track_seq", 32'(seen.size()), 32'd1);
    bus.din = 10'd1023;
    bus.sustain_level = 10'd511;
    run_until_level(511, 20);
    cycle();
    check("dout_half", 32'(bus.dout), 32'd511);
    bus.din = 10'd512;
    bus.sustain_level = 10'd1023;
    run_until_level(1023, 20);
    cycle();
    check("dout_full", 32'(bus.dout), 32'd512);
    bus.sustain_level = 10'd600;
    run_until_level(600, 20);

    // Release to idle, then zero envelope silences dout
    bus.gate = 1'b0;
    run_until_state(M_IDLE, 100);
    check_seq("release_seq", seq_rel, 3);
    check("idle_active", 32'(bus.active), 32'd0);
    bus.din = 10'd1023;
    cycle();
    check("dout_zero", 32'(bus.dout), 32'd0);

    // Retrigger from release at 400 without dropping to zero
    bus.gate = 1'b1;
    run_until_state(M_SUS, 200);
    bus.gate = 1'b0;
    run_until_level(400, 40);
    bus.attack_rate = 8'd100;
    bus.gate = 1'b1;
    cycle();
    check("retrig_state", 32'(bus.state), 32'(M_ATK));
    check("retrig_level", 32'(bus.env_level), 32'd400);
    run_until_level(500, 20);
    check_seq("retrig_seq", seq_one, 1);

    // Gate events coincident with a tick suppress that tick's update
    align_to_tick();
    lvl = int'(bus.env_level);
    bus.gate = 1'b0;
    cycle();
    check("coinc_fall_state", 32'(bus.state), 32'(M_REL));
    check("coinc_fall_level", 32'(bus.env_level), 32'(lvl));
    align_to_tick();
    lvl = int'(bus.env_level);
    bus.gate = 1'b1;
    cycle();
    check("coinc_rise_state", 32'(bus.state), 32'(M_ATK));
    check("coinc_rise_level", 32'(bus.env_level), 32'(lvl));

    // Asynchronous reset mid-attack, released with gate held high
    for (int i = 0; i < 6; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("async_env", 32'(bus.env_level), 32'd0);
    check("async_dout", 32'(bus.dout), 32'd0);
    check("async_state", 32'(bus.state), 32'd0);
    check("async_active", 32'(bus.active), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    cycle();
    check("post_rst_attack", 32'(bus.state), 32'(M_ATK));

    // Random gate, rate, sustain and sample activity
    for (int i = 0; i < 4000; i++) begin
      bus.din = 10'($urandom_range(0, MAXL));
      if ($urandom_range(0, 59) == 0) bus.gate = ~bus.gate;
      if ($urandom_range(0, 49) == 0) bus.attack_rate  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) bus.decay_rate   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) bus.release_rate = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) bus.sustain_level = 10'($urandom_range(0, MAXL));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
